ahb_bm_output_arbiter: RTL and testbench

//  Per-slave-port arbiter in the AHB bus matrix output stage. Shares one slave

---
 rtl/ahb_bm_output_arbiter.sv | 96 +++++++++
 tb/tb_ahb_bm_output_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_bm_output_arbiter.sv
// Round-robin arbiter for one bus-matrix slave port. It holds the grant through
// bursts and locked sequences, and tracks the data-phase owner for response routing.
//
//  state  | meaning
//  NOPORT | no address-phase owner; the output stage drives IDLE
//  GRANT  | owner holds the port while its htrans is SEQ or BUSY
//  LOCKED | owner holds the port while its hmastlock stays high
module ahb_bm_output_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [NUM_MASTERS-1:0]   req,
    input  logic [2*NUM_MASTERS-1:0] htrans,
    input  logic [NUM_MASTERS-1:0]   hmastlock,
    input  logic                     HREADYM,
    output logic [IDX_W-1:0]         addr_sel,
    output logic                     no_port,
    output logic [IDX_W-1:0]         data_sel,
    output logic                     data_valid
);

    typedef enum logic [1:0] {NOPORT, GRANT, LOCKED} state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [1:0]       own_htrans;
    logic             own_lock;
    logic             win_found;
    logic [IDX_W-1:0] winner;
    logic             win_lock;
    logic             hold;
    logic             dphase;
    int               idx;

    always_comb begin
        own_htrans = 2'b00;
        own_lock   = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (addr_sel == IDX_W'(i)) begin
                own_htrans = htrans[2*i +: 2];
                own_lock   = hmastlock[i];
            end
        end
    end

    // Search starts just past the last winner and wraps; works for any NUM_MASTERS.
    always_comb begin
        win_found = 1'b0;
        winner    = '0;
        win_lock  = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_MASTERS;
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (!win_found && (j == idx) && req[j]) begin
                    win_found = 1'b1;
                    winner    = IDX_W'(j);
                    win_lock  = hmastlock[j];
                end
            end
        end
    end

    assign hold   = ((state == GRANT) && own_htrans[0]) ||
                    ((state == LOCKED) && own_lock);
    assign dphase = ~no_port & own_htrans[1];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= NOPORT;
            rr_ptr     <= IDX_W'(NUM_MASTERS - 1);
            addr_sel   <= '0;
            no_port    <= 1'b1;
            data_sel   <= '0;
            data_valid <= 1'b0;
        end else if (HREADYM) begin
            data_valid <= dphase;
            if (dphase)
                data_sel <= addr_sel;
            if (!hold) begin
                if (win_found) begin
                    addr_sel <= winner;
                    rr_ptr   <= winner;
                    no_port  <= 1'b0;
                    state    <= win_lock ? LOCKED : GRANT;
                end else begin
                    no_port  <= 1'b1;
                    state    <= NOPORT;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_bm_output_arbiter.sv
// Bench for ahb_bm_output_arbiter: directed scenarios plus random traffic, all
// checked against an owner/round-robin reference model.
module tb_ahb_bm_output_arbiter;

    localparam int N = 4;

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic [N-1:0] req;
    logic [2*N-1:0] htrans;
    logic [N-1:0] hmastlock;
    logic         HREADYM;
    logic [1:0]   addr_sel;
    logic         no_port;
    logic [1:0]   data_sel;
    logic         data_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model: who owns the port, why it is held, last winner, data phase
    int m_own, m_last, m_dsel;
    bit m_has, m_lk, m_dv;

    ahb_bm_output_arbiter #(.NUM_MASTERS(N), .IDX_W(2)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .htrans(htrans),
        .hmastlock(hmastlock), .HREADYM(HREADYM), .addr_sel(addr_sel),
        .no_port(no_port), .data_sel(data_sel), .data_valid(data_valid)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_last = N - 1; m_dsel = 0;
        m_has = 0; m_lk = 0; m_dv = 0;
    endtask

    task automatic model_edge();
        logic [1:0] oh;
        bit held, nd;
        int w, c;
        if (HRESETn !== 1'b1) begin
            model_reset();
        end else if (HREADYM === 1'b1) begin
            oh   = htrans[2*m_own +: 2];
            nd   = m_has && oh[1];
            held = m_has && (m_lk ? hmastlock[m_own] : oh[0]);
            m_dv = nd;
            if (nd) m_dsel = m_own;
            if (!held) begin
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (w < 0 && req[c]) w = c;
                end
                if (w >= 0) begin
                    m_own = w; m_last = w; m_has = 1; m_lk = hmastlock[w];
                end else begin
                    m_has = 0; m_lk = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr_sel"},   addr_sel,   m_own);
        chk({tag, ".no_port"},    no_port,    32'(!m_has));
        chk({tag, ".data_sel"},   data_sel,   m_dsel);
        chk({tag, ".data_valid"}, data_valid, 32'(m_dv));
    endtask

    task automatic step(input string tag);
        @(posedge HCLK);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic set_ht(input int m, input logic [1:0] v);
        htrans[2*m +: 2] = v;
    endtask

    initial begin
        int rr_exp [4];
        HRESETn = 1'b0; HREADYM = 1'b1; req = 4'b1111;
        htrans = 8'hAA; hmastlock = 4'b0000;
        model_reset();

        // reset held while everybody requests
        repeat (3) @(posedge HCLK);
        #1;
        check_all("t1_rst");
        HRESETn = 1'b1;
        step("t1_rel");
        chk("t1_first_grant", addr_sel, 0);
        chk("t1_first_noport", no_port, 0);

        // round robin over all NONSEQ requesters
        rr_exp = '{1, 2, 3, 0};
        for (int k = 0; k < 4; k++) begin
            step("t2_rr");
            chk("t2_rr_addr", addr_sel, rr_exp[k]);
            chk("t2_rr_data", data_sel, (rr_exp[k] + 3) % 4);
        end

        // burst hold for master 1 with BUSY in the middle, master 2 waiting
        req = 4'b0110; htrans = 8'h00; set_ht(1, 2'b10); set_ht(2, 2'b10);
        step("t3_grant");
        chk("t3_grant1", addr_sel, 1);
        set_ht(1, 2'b11); step("t3_seq1");  chk("t3_hold_a", addr_sel, 1);
        set_ht(1, 2'b01); step("t3_busy");  chk("t3_hold_b", addr_sel, 1);
        chk("t3_busy_dv", data_valid, 0);
        set_ht(1, 2'b11); step("t3_seq2");  chk("t3_hold_c", addr_sel, 1);
        set_ht(1, 2'b11); step("t3_seq3");  chk("t3_hold_d", addr_sel, 1);
        set_ht(1, 2'b00); req = 4'b0100; step("t3_end");
        chk("t3_to2", addr_sel, 2);

        // wait states with master 2 owning, then it drops req
        set_ht(2, 2'b11); step("t4_own");
        HREADYM = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step("t4_wait");
            chk("t4_wait_addr", addr_sel, 2);
        end
        req = 4'b0000; set_ht(2, 2'b00);
        step("t4_drop");
        chk("t4_drop_addr", addr_sel, 2);
        chk("t4_drop_dv", data_valid, 1);
        HREADYM = 1'b1;
        step("t4_adv");
        chk("t4_adv_noport", no_port, 1);

        // locked sequence from master 3 while master 0 requests
        req = 4'b1001; hmastlock = 4'b1000; htrans = 8'h00; set_ht(3, 2'b10); set_ht(0, 2'b10);
        step("t5_grant");
        chk("t5_grant3", addr_sel, 3);
        set_ht(3, 2'b10); step("t5_l1"); chk("t5_lock_a", addr_sel, 3);
        set_ht(3, 2'b00); step("t5_l2"); chk("t5_lock_b", addr_sel, 3);
        set_ht(3, 2'b10); step("t5_l3"); chk("t5_lock_c", addr_sel, 3);
        hmastlock = 4'b0000; req = 4'b0001; set_ht(3, 2'b00);
        step("t5_unlock");
        chk("t5_to0", addr_sel, 0);

        // idle, then a single NONSEQ from master 2 with a two-cycle ERROR
        req = 4'b0000; htrans = 8'h00;
        step("t6_idle_a"); step("t6_idle_b");
        chk("t6_noport", no_port, 1);
        chk("t6_dv", data_valid, 0);
        req = 4'b0100; set_ht(2, 2'b10);
        step("t6_grant");
        step("t6_nonseq");
        chk("t6_dsel", data_sel, 2);
        req = 4'b0000; set_ht(2, 2'b00); HREADYM = 1'b0;
        step("t6_err1"); chk("t6_err1_dsel", data_sel, 2);
        HREADYM = 1'b1;
        step("t6_err2"); chk("t6_err2_dsel", data_sel, 2);

        // random traffic, with one asynchronous reset in the middle
        for (int k = 0; k < 400; k++) begin
            req       = N'($urandom);
            htrans    = (2*N)'($urandom);
            hmastlock = N'($urandom & $urandom);
            HREADYM   = ($urandom_range(0, 3) != 0);
            if (k == 200) begin
                #2;
                HRESETn = 1'b0;
                model_reset();
                #1;
                check_all("rnd_async_rst");
                HREADYM = 1'b1;
                step("rnd_in_rst");
                HRESETn = 1'b1;
            end
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
